// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding,
// requester indices and the default acknowledge timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  // Requester indices; also the value driven on the mux select line.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

  // BUSY cycles allowed without an acknowledge before the access is aborted.
  localparam int DEFAULT_MAX_WAIT = 15;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser. On a tie the requester that did not own
// the port last wins; otherwise the single active requester wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  // Pure combinational pick; winner is meaningful only while valid is high.
  always_comb begin
    valid  = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else begin
      winner = req1 ? REQ_LSU : REQ_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for one shared memory port
// (port 0 = instruction fetch, port 1 = load/store). The winning request
// is registered and held until the memory acknowledges or the wait
// counter times out; read data is returned with a one-cycle done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mux_sel,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  // The counter holds the number of ack-less BUSY cycles already elapsed.
  // When it shows MAX_WAIT-1 and this cycle also has no ack, the counter
  // reaches MAX_WAIT now and the access is aborted at this edge.
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

  arb_state_t      state_reg;
  logic            last_owner_reg;
  logic [CW-1:0]   cnt_reg;

  logic            busy;
  logic            illegal;
  logic            owner;
  logic            ack_done;
  logic            timeout;
  logic            pick_last;
  logic            pick_valid;
  logic            pick_winner;
  logic            do_grant;
  logic            do_release;
  logic [DATA_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic            cap_we;

  // Decode current state and completion events; the ack path arbitrates
  // with last_owner already updated to the finishing requester.
  always_comb begin
    busy      = (state_reg == BUSY0) || (state_reg == BUSY1);
    illegal   = !busy && (state_reg != IDLE);
    owner     = (state_reg == BUSY1) ? REQ_LSU : REQ_FETCH;
    ack_done  = busy & mem_ack;
    timeout   = busy & ~mem_ack & (cnt_reg == CNT_LAST);
    pick_last = ack_done ? owner : last_owner_reg;
  end

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (pick_last),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Select the request to capture and decide between grant, release or wait.
  always_comb begin
    do_grant   = pick_valid & ((state_reg == IDLE) | ack_done);
    do_release = (ack_done & ~pick_valid) | timeout | illegal;
    cap_addr   = pick_winner ? addr1 : addr0;
    cap_wdata  = pick_winner ? wdata1 : '0;
    cap_we     = pick_winner & we1;
  end

  // Arbitration FSM with registered grants, memory request and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_owner_reg <= REQ_LSU;
      cnt_reg        <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      err0           <= 1'b0;
      err1           <= 1'b0;
      mux_sel        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      rdata          <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;

      if (ack_done) begin
        rdata          <= mem_rdata;
        done0          <= ~owner;
        done1          <= owner;
        last_owner_reg <= owner;
      end

      if (timeout) begin
        err0           <= ~owner;
        err1           <= owner;
        last_owner_reg <= owner;
      end

      if (do_grant) begin
        state_reg <= pick_winner ? BUSY1 : BUSY0;
        gnt0      <= ~pick_winner;
        gnt1      <= pick_winner;
        mux_sel   <= pick_winner;
        mem_req   <= 1'b1;
        mem_we    <= cap_we;
        mem_addr  <= cap_addr;
        mem_wdata <= cap_wdata;
        cnt_reg   <= '0;
      end else if (do_release) begin
        state_reg <= IDLE;
        gnt0      <= 1'b0;
        gnt1      <= 1'b0;
        mux_sel   <= 1'b0;
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        cnt_reg   <= '0;
      end else if (busy && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. The driver pushes the expected
// completion of each access into a queue; a monitor pops and compares
// whenever the DUT pulses done/err, and checks grant invariants each cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we1;
  logic [31:0] addr0, addr1, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        mux_sel, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        port;
    logic        is_err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] snap_addr  = '0;
  logic [31:0] snap_wdata = '0;
  logic        snap_we    = 1'b0;

  mem_port_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .addr0     (addr0),
    .req1      (req1),
    .addr1     (addr1),
    .we1       (we1),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .err0      (err0),
    .err1      (err1),
    .rdata     (rdata),
    .mux_sel   (mux_sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic port, input logic is_err, input logic [31:0] rd,
                          input logic [31:0] addr, input logic we, input logic [31:0] wd);
    exp_t e;
    e.port   = port;
    e.is_err = is_err;
    e.rdata  = rd;
    e.addr   = addr;
    e.we     = we;
    e.wdata  = wd;
    exp_q.push_back(e);
  endtask

  task automatic expect_idle(input string tag);
    check1({tag, "_mem_req"}, mem_req, 1'b0);
    check1({tag, "_gnt0"},    gnt0,    1'b0);
    check1({tag, "_gnt1"},    gnt1,    1'b0);
    check1({tag, "_mux_sel"}, mux_sel, 1'b0);
    check1({tag, "_mem_we"},  mem_we,  1'b0);
    check1({tag, "_done0"},   done0,   1'b0);
    check1({tag, "_done1"},   done1,   1'b0);
    check1({tag, "_err0"},    err0,    1'b0);
    check1({tag, "_err1"},    err1,    1'b0);
  endtask

  task automatic expect_reset_zero(input string tag);
    expect_idle(tag);
    check32({tag, "_rdata"},     rdata,     32'h0);
    check32({tag, "_mem_addr"},  mem_addr,  32'h0);
    check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic expect_bus(input string tag, input logic g0, input logic g1,
                            input logic [31:0] addr, input logic we, input logic [31:0] wd);
    check1({tag, "_mem_req"},    mem_req,   1'b1);
    check1({tag, "_gnt0"},       gnt0,      g0);
    check1({tag, "_gnt1"},       gnt1,      g1);
    check1({tag, "_mux_sel"},    mux_sel,   g1);
    check1({tag, "_mem_we"},     mem_we,    we);
    check32({tag, "_mem_addr"},  mem_addr,  addr);
    check32({tag, "_mem_wdata"}, mem_wdata, wd);
  endtask

  // Scoreboard monitor: compares every done/err pulse against the queue head
  // and the request that was on the memory bus in the previous cycle.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 || done1 || err0 || err1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=done0:%b done1:%b err0:%b err1:%b required=none",
                   done0, done1, err0, err1);
        end else begin
          e = exp_q.pop_front();
          check1("pulse_port", done1 | err1, e.port);
          check1("pulse_err",  err0 | err1,  e.is_err);
          if (!e.is_err) check32("rdata", rdata, e.rdata);
          check32("req_addr",  snap_addr,  e.addr);
          check1("req_we",     snap_we,    e.we);
          check32("req_wdata", snap_wdata, e.wdata);
          $display("txn port=%0d %s addr=0x%08h we=%b rdata=0x%08h",
                   done1 | err1, (err0 | err1) ? "err " : "done", snap_addr, snap_we, rdata);
        end
      end
      check1("gnt_exclusive", gnt0 & gnt1, 1'b0);
      check1("mux_sel_eq_gnt1", mux_sel, gnt1);
      snap_addr  = mem_addr;
      snap_we    = mem_we;
      snap_wdata = mem_wdata;
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata1 = '0; mem_ack = 1'b0; mem_rdata = '0;
    fork
      monitor_loop();
    join_none

    // 1. Reset, idle for 10 cycles, spurious ack ignored.
    tick(); tick();
    rst = 1'b0;
    expect_reset_zero("t1_reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      mem_ack = (i == 4);
      mem_rdata = 32'hFFFF_0000;
      expect_idle("t1_idle");
    end
    mem_ack = 1'b0;

    // 2. Single fetch acked 3 cycles after mem_req.
    req0 = 1'b1; addr0 = 32'h0000_0100;
    tick();
    expect_bus("t2_grant", 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
    req0 = 1'b0;
    tick(); tick(); tick();
    expect_bus("t2_hold", 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    push_exp(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h100, 1'b0, 32'h0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check1("t2_done0", done0, 1'b1);
    check1("t2_released", mem_req, 1'b0);

    // 3. Contention: reset restores last_owner=1, then grants go 0,1,0,1.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    req0 = 1'b1; addr0 = 32'h0000_0200;
    req1 = 1'b1; addr1 = 32'h0000_0300; we1 = 1'b1; wdata1 = 32'h1234_5678;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic        p;
      logic [31:0] a, wd, rd;
      p  = k[0];
      a  = p ? 32'h300 : 32'h200;
      wd = p ? 32'h1234_5678 : 32'h0;
      rd = 32'hA000_0000 + 32'(k);
      expect_bus("t3_grant", ~p, p, a, p, wd);
      tick();
      expect_bus("t3_ackcyc", ~p, p, a, p, wd);
      mem_ack = 1'b1; mem_rdata = rd;
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      push_exp(p, 1'b0, rd, a, p, wd);
      tick();
      mem_ack = 1'b0;
    end
    check1("t3_done1_last", done1, 1'b1);
    check1("t3_released", mem_req, 1'b0);

    // 4. Timeout on requester 1; next tie favours requester 0.
    we1 = 1'b0; addr1 = 32'h0000_0400; wdata1 = 32'hCAFE_0000; req1 = 1'b1;
    tick();
    expect_bus("t4_grant", 1'b0, 1'b1, 32'h400, 1'b0, 32'hCAFE_0000);
    for (int i = 1; i < 15; i++) begin
      tick();
      check1("t4_wait_mem_req", mem_req, 1'b1);
      check1("t4_no_early_err", err1, 1'b0);
    end
    push_exp(1'b1, 1'b1, 32'h0, 32'h400, 1'b0, 32'hCAFE_0000);
    tick();
    check1("t4_err1", err1, 1'b1);
    check1("t4_no_done1", done1, 1'b0);
    check1("t4_mem_req_drop", mem_req, 1'b0);
    check1("t4_gnt1_drop", gnt1, 1'b0);
    req0 = 1'b1; addr0 = 32'h0000_0500;
    tick();
    expect_bus("t4_regrant", 1'b1, 1'b0, 32'h500, 1'b0, 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    push_exp(1'b0, 1'b0, 32'h5555_AAAA, 32'h500, 1'b0, 32'h0);
    tick();
    mem_ack = 1'b0;

    // 5. Ack on the cycle the timeout would fire: done wins, no err.
    req0 = 1'b1; addr0 = 32'h0000_0700;
    tick();
    expect_bus("t5_grant", 1'b1, 1'b0, 32'h700, 1'b0, 32'h0);
    req0 = 1'b0;
    for (int i = 1; i < 15; i++) begin
      tick();
      check1("t5_wait_mem_req", mem_req, 1'b1);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    push_exp(1'b0, 1'b0, 32'h0BAD_F00D, 32'h700, 1'b0, 32'h0);
    tick();
    mem_ack = 1'b0;
    check1("t5_done0", done0, 1'b1);
    check1("t5_no_err0", err0, 1'b0);

    // 6. Reset mid-transaction discards the in-flight ack.
    req0 = 1'b1; addr0 = 32'h0000_0800;
    tick();
    expect_bus("t6_grant", 1'b1, 1'b0, 32'h800, 1'b0, 32'h0);
    req0 = 1'b0;
    tick();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0;
    expect_reset_zero("t6_reset");
    tick();
    mem_ack = 1'b0;
    expect_idle("t6_idle_a");
    tick();
    expect_idle("t6_idle_b");
    req0 = 1'b1; addr0 = 32'h0000_0900;
    tick();
    expect_bus("t6_fresh", 1'b1, 1'b0, 32'h900, 1'b0, 32'h0);
    req0 = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    push_exp(1'b0, 1'b0, 32'h1357_9BDF, 32'h900, 1'b0, 32'h0);
    tick();
    mem_ack = 1'b0;
    check1("t6_fresh_done0", done0, 1'b1);

    tick(); tick(); tick();
    check32("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
